// File: rtl/approx_mult_error_monitor.sv
// Streaming error-metric accumulator for approximate-multiplier characterisation.
// Stage 1 forms the error distance of each accepted pair; stage 2 folds it into saturating sums.
module approx_mult_error_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 32,
   parameter int ACC_W = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   in_exact,
   input  logic [2*WIDTH-1:0]   in_apprx,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     accepted,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     nz_count,
   output logic [ACC_W-1:0]     sum_aed,
   output logic [ACC_W-1:0]     sum_ed,
   output logic [2*WIDTH-1:0]   max_aed,
   output logic [2*WIDTH-1:0]   max_exact,
   output logic                 sat
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_accepted;

   logic             r_s1_valid;
   logic [PW:0]      r_s1_d;
   logic [PW-1:0]    r_s1_a;
   logic             r_s1_ne;
   logic             r_s1_nz;
   logic [PW-1:0]    r_s1_exact;

   logic [CNT_W-1:0] r_err_count;
   logic [CNT_W-1:0] r_nz_count;
   logic [ACC_W-1:0] r_sum_aed;
   logic [ACC_W-1:0] r_sum_ed;
   logic [PW-1:0]    r_max_aed;
   logic [PW-1:0]    r_max_exact;
   logic             r_sat;

   logic             w_in_ready;
   logic             w_xfer;
   logic             w_last_xfer;
   logic [PW:0]      w_d;
   logic [PW-1:0]    w_a;
   logic [ACC_W:0]   w_aed_sum;
   logic             w_aed_ovf;
   logic [ACC_W-1:0] w_aed_nxt;
   logic [ACC_W:0]   w_ed_sum;
   logic             w_ed_ovf;
   logic [ACC_W-1:0] w_ed_nxt;

   // ------------------------------------------------------------------
   // Input handshake
   // ------------------------------------------------------------------
   assign w_in_ready  = (r_state == S_RUN) && (r_accepted < r_target);
   assign w_xfer      = in_valid && w_in_ready;
   assign w_last_xfer = w_xfer && ((r_accepted + CNT_W'(1)) == r_target);

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = (num_samples == '0) ? S_DONE : S_RUN;
      end else begin
         case (r_state)
            S_RUN:   if (w_last_xfer || !w_in_ready) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_s1_valid) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: error distance of the pair accepted this cycle
   // ------------------------------------------------------------------
   assign w_d = {1'b0, in_exact} - {1'b0, in_apprx};
   assign w_a = (in_exact >= in_apprx) ? (in_exact - in_apprx) : (in_apprx - in_exact);

   // start wins over a coincident transfer: the pair is dropped with the old run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_target   <= '0;
         r_accepted <= '0;
         r_s1_valid <= 1'b0;
         r_s1_d     <= '0;
         r_s1_a     <= '0;
         r_s1_ne    <= 1'b0;
         r_s1_nz    <= 1'b0;
         r_s1_exact <= '0;
      end else if (start) begin
         r_target   <= num_samples;
         r_accepted <= '0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_accepted <= r_accepted + CNT_W'(1);
            r_s1_d     <= w_d;
            r_s1_a     <= w_a;
            r_s1_ne    <= (in_exact != in_apprx);
            r_s1_nz    <= (in_exact != '0);
            r_s1_exact <= in_exact;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: saturating accumulation and peak tracking
   // ------------------------------------------------------------------
   assign w_aed_sum = {1'b0, r_sum_aed} + {{(ACC_W + 1 - PW){1'b0}}, r_s1_a};
   assign w_aed_ovf = w_aed_sum[ACC_W];
   assign w_aed_nxt = w_aed_ovf ? '1 : w_aed_sum[ACC_W-1:0];

   // One guard bit: the two top bits disagree exactly when the signed sum left range.
   assign w_ed_sum = {r_sum_ed[ACC_W-1], r_sum_ed} + {{(ACC_W - PW){r_s1_d[PW]}}, r_s1_d};
   assign w_ed_ovf = w_ed_sum[ACC_W] ^ w_ed_sum[ACC_W-1];
   assign w_ed_nxt = !w_ed_ovf       ? w_ed_sum[ACC_W-1:0] :
                     w_ed_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} :
                                       {1'b0, {(ACC_W - 1){1'b1}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= '0;
         r_nz_count  <= '0;
         r_sum_aed   <= '0;
         r_sum_ed    <= '0;
         r_max_aed   <= '0;
         r_max_exact <= '0;
         r_sat       <= 1'b0;
      end else if (start) begin
         r_err_count <= '0;
         r_nz_count  <= '0;
         r_sum_aed   <= '0;
         r_sum_ed    <= '0;
         r_max_aed   <= '0;
         r_max_exact <= '0;
         r_sat       <= 1'b0;
      end else if (r_s1_valid) begin
         r_err_count <= r_err_count + CNT_W'(r_s1_ne);
         r_nz_count  <= r_nz_count + CNT_W'(r_s1_nz);
         r_sum_aed   <= w_aed_nxt;
         r_sum_ed    <= w_ed_nxt;
         r_sat       <= r_sat | w_aed_ovf | w_ed_ovf;
         // Strictly greater keeps the first occurrence on ties.
         if (r_s1_a > r_max_aed) begin
            r_max_aed   <= r_s1_a;
            r_max_exact <= r_s1_exact;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready  = w_in_ready;
   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign accepted  = r_accepted;
   assign err_count = r_err_count;
   assign nz_count  = r_nz_count;
   assign sum_aed   = r_sum_aed;
   assign sum_ed    = r_sum_ed;
   assign max_aed   = r_max_aed;
   assign max_exact = r_max_exact;
   assign sat       = r_sat;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Scoreboard bench: two monitors (ACC_W=48 and ACC_W=18) share one stimulus stream;
// per-run expectations come from an arithmetic reference model and are popped when done rises.
module tb_approx_mult_error_monitor;

   localparam int WIDTH = 8;
   localparam int CNT_W = 32;
   localparam int PW    = 2 * WIDTH;
   localparam int ACC_W = 48;
   localparam int ACC_S = 18;

   typedef struct {
      int e;
      int a;
   } pair_t;

   typedef struct {
      longint acc;
      longint err;
      longint nz;
      longint aed;
      longint ed;
      longint mx;
      longint mxe;
      longint sat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_samples = '0;
   logic             in_valid = 1'b0;
   logic [PW-1:0]    in_exact = '0;
   logic [PW-1:0]    in_apprx = '0;

   logic             in_ready, busy, done, sat;
   logic [CNT_W-1:0] accepted, err_count, nz_count;
   logic [ACC_W-1:0] sum_aed, sum_ed;
   logic [PW-1:0]    max_aed, max_exact;

   logic             s_in_ready, s_busy, s_done, s_sat;
   logic [CNT_W-1:0] s_accepted, s_err_count, s_nz_count;
   logic [ACC_S-1:0] s_sum_aed, s_sum_ed;
   logic [PW-1:0]    s_max_aed, s_max_exact;

   int               checks = 0;
   int               failures = 0;
   exp_t             q48[$];
   exp_t             q18[$];

   approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_exact(in_exact), .in_apprx(in_apprx),
      .busy(busy), .done(done), .accepted(accepted), .err_count(err_count),
      .nz_count(nz_count), .sum_aed(sum_aed), .sum_ed(sum_ed),
      .max_aed(max_aed), .max_exact(max_exact), .sat(sat)
   );

   approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) u_sat (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_exact(in_exact), .in_apprx(in_apprx),
      .busy(s_busy), .done(s_done), .accepted(s_accepted), .err_count(s_err_count),
      .nz_count(s_nz_count), .sum_aed(s_sum_aed), .sum_ed(s_sum_ed),
      .max_aed(s_max_aed), .max_exact(s_max_exact), .sat(s_sat)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: plain arithmetic over the list of accepted pairs
   // ------------------------------------------------------------------
   function automatic exp_t model(input pair_t p[$], input int acc_w);
      exp_t   r;
      longint aed_lim = (64'sd1 <<< acc_w) - 1;
      longint ed_hi   = (64'sd1 <<< (acc_w - 1)) - 1;
      longint ed_lo   = -(64'sd1 <<< (acc_w - 1));
      r = '{default: 0};
      r.acc = p.size();
      foreach (p[i]) begin
         longint d  = longint'(p[i].e) - longint'(p[i].a);
         longint ad = (d < 0) ? -d : d;
         if (d != 0) r.err++;
         if (p[i].e != 0) r.nz++;
         r.aed += ad;
         if (r.aed > aed_lim) begin r.aed = aed_lim; r.sat = 1; end
         r.ed += d;
         if (r.ed > ed_hi) begin r.ed = ed_hi; r.sat = 1; end
         if (r.ed < ed_lo) begin r.ed = ed_lo; r.sat = 1; end
         if (ad > r.mx) begin r.mx = ad; r.mxe = p[i].e; end
      end
      return r;
   endfunction

   function automatic pair_t rand_pair();
      pair_t r;
      int    k = int'($urandom_range(0, 3));
      r.e = int'($urandom_range(0, 65535));
      case (k)
         0: r.a = r.e;
         1: begin r.e = 0; r.a = int'($urandom_range(0, 65535)); end
         2: begin
            r.a = r.e + int'($urandom_range(0, 512)) - 256;
            if (r.a < 0) r.a = 0;
            if (r.a > 65535) r.a = 65535;
         end
         default: r.a = int'($urandom_range(0, 65535));
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Check helpers
   // ------------------------------------------------------------------
   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bounded wait expired", name);
   endtask

   task automatic cmp(input string tag, input exp_t e, input longint acc, input longint err,
                      input longint nz, input longint aed, input longint ed, input longint mx,
                      input longint mxe, input longint st);
      check({tag, ".accepted"},  acc, e.acc);
      check({tag, ".err_count"}, err, e.err);
      check({tag, ".nz_count"},  nz,  e.nz);
      check({tag, ".sum_aed"},   aed, e.aed);
      check({tag, ".sum_ed"},    ed,  e.ed);
      check({tag, ".max_aed"},   mx,  e.mx);
      check({tag, ".max_exact"}, mxe, e.mxe);
      check({tag, ".sat"},       st,  e.sat);
   endtask

   task automatic zero_all(input string tag);
      check({tag, ".in_ready"}, in_ready, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".accepted"}, accepted, 0);
      check({tag, ".err_count"}, err_count, 0);
      check({tag, ".nz_count"}, nz_count, 0);
      check({tag, ".sum_aed"}, sum_aed, 0);
      check({tag, ".sum_ed"}, sum_ed, 0);
      check({tag, ".max_aed"}, max_aed, 0);
      check({tag, ".max_exact"}, max_exact, 0);
      check({tag, ".sat"}, sat, 0);
      check({tag, ".s_in_ready"}, s_in_ready, 0);
      check({tag, ".s_busy"}, s_busy, 0);
      check({tag, ".s_done"}, s_done, 0);
      check({tag, ".s_accepted"}, s_accepted, 0);
      check({tag, ".s_err_count"}, s_err_count, 0);
      check({tag, ".s_nz_count"}, s_nz_count, 0);
      check({tag, ".s_sum_aed"}, s_sum_aed, 0);
      check({tag, ".s_sum_ed"}, s_sum_ed, 0);
      check({tag, ".s_max_aed"}, s_max_aed, 0);
      check({tag, ".s_max_exact"}, s_max_exact, 0);
      check({tag, ".s_sat"}, s_sat, 0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic plan_run(input pair_t p[$]);
      q48.push_back(model(p, ACC_W));
      q18.push_back(model(p, ACC_S));
   endtask

   task automatic do_start(input int n);
      @(negedge clk);
      start = 1'b1;
      num_samples = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_pair(input pair_t p);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_exact = p.e[PW-1:0];
      in_apprx = p.a[PW-1:0];
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail("in_ready_wait");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail("done_wait");
   endtask

   // ------------------------------------------------------------------
   // Monitor: pop and compare whenever a run completes on either instance
   // ------------------------------------------------------------------
   logic mon_prev_d = 1'b0;
   logic mon_prev_s = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && !mon_prev_d) begin
            if (q48.size() == 0) begin
               fail("unexpected_done48");
            end else begin
               e = q48.pop_front();
               cmp("run48", e, accepted, err_count, nz_count, sum_aed, $signed(sum_ed),
                   max_aed, max_exact, sat);
            end
         end
         if (s_done && !mon_prev_s) begin
            if (q18.size() == 0) begin
               fail("unexpected_done18");
            end else begin
               e = q18.pop_front();
               cmp("run18", e, s_accepted, s_err_count, s_nz_count, s_sum_aed, $signed(s_sum_ed),
                   s_max_aed, s_max_exact, s_sat);
            end
         end
         mon_prev_d = done;
         mon_prev_s = s_done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      pair_t p[$];
      pair_t tbl[5];
      pair_t ab[$];
      int    xfer;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      zero_all("reset");
      rst = 1'b0;

      // Zero-sample run from IDLE: DONE one cycle after start, everything zero.
      p = {};
      plan_run(p);
      do_start(0);
      check("n0.done", done, 1);
      check("n0.in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      check("n0.in_ready_later", in_ready, 0);

      // Directed run with a tie on the peak and latency check.
      p = {};
      p.push_back('{100, 96});
      p.push_back('{50, 50});
      p.push_back('{0, 4});
      plan_run(p);
      do_start(3);
      foreach (p[i]) send_pair(p[i]);
      @(negedge clk);
      check("lat.accepted", accepted, 3);
      check("lat.in_ready", in_ready, 0);
      check("lat.done_t0", done, 0);
      @(negedge clk);
      check("lat.done_t1", done, 0);
      @(negedge clk);
      check("lat.done_t2", done, 1);

      // in_valid held for 5 cycles with a target of 2.
      foreach (tbl[i]) tbl[i] = rand_pair();
      p = {};
      p.push_back(tbl[0]);
      p.push_back(tbl[1]);
      plan_run(p);
      do_start(2);
      xfer = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_exact = tbl[i].e[PW-1:0];
         in_apprx = tbl[i].a[PW-1:0];
         check($sformatf("hs.in_ready%0d", i), in_ready, (xfer < 2) ? 1 : 0);
         if (in_ready) xfer++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("hs.transfers", xfer, 2);
      check("hs.accepted", accepted, 2);
      wait_done();

      // Saturation on the narrow instance, then restart clears it.
      p = {};
      for (int i = 0; i < 8; i++) p.push_back('{65025, 0});
      plan_run(p);
      do_start(8);
      foreach (p[i]) send_pair(p[i]);
      wait_done();
      @(negedge clk);
      check("sat.s_sat_held", s_sat, 1);
      check("sat.s_sum_aed_held", s_sum_aed, 262143);
      p = {};
      for (int i = 0; i < 3; i++) p.push_back(rand_pair());
      plan_run(p);
      do_start(3);
      check("restart.s_sat", s_sat, 0);
      check("restart.s_sum_aed", s_sum_aed, 0);
      check("restart.done", done, 0);
      foreach (p[i]) send_pair(p[i]);
      wait_done();

      // start mid-run: the 5 pairs of the abandoned run must not contribute.
      ab = {};
      for (int i = 0; i < 10; i++) ab.push_back(rand_pair());
      do_start(10);
      for (int i = 0; i < 5; i++) send_pair(ab[i]);
      p = {};
      for (int i = 0; i < 4; i++) p.push_back('{10, 7});
      plan_run(p);
      do_start(4);
      check("abort.accepted", accepted, 0);
      check("abort.sum_aed", sum_aed, 0);
      foreach (p[i]) send_pair(p[i]);
      wait_done();

      // Asynchronous reset pulse during DRAIN.
      ab = {};
      ab.push_back('{300, 1});
      ab.push_back('{7, 9});
      ab.push_back('{1000, 999});
      do_start(3);
      foreach (ab[i]) send_pair(ab[i]);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 zero_all("midrst");
      #1 rst = 1'b0;
      @(negedge clk);
      check("postrst.busy", busy, 0);
      check("postrst.done", done, 0);

      // Randomised runs with random idle gaps.
      for (int r = 0; r < 6; r++) begin
         int n = int'($urandom_range(1, 12));
         p = {};
         for (int i = 0; i < n; i++) p.push_back(rand_pair());
         plan_run(p);
         do_start(n);
         foreach (p[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_pair(p[i]);
         end
         wait_done();
      end

      repeat (3) @(negedge clk);
      check("q48_drained", q48.size(), 0);
      check("q18_drained", q18.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
Streaming hardware error-metric accumulator for approximate-multiplier characterisation. It accepts pairs of products, one exact and one approximate, through a valid/ready handshake. Over a programmed sample count it accumulates error count, signed and absolute error-distance sums, peak absolute error and non-zero-exact count. Host software derives ER, MED, MNED and normalised figures from these registers; no divider is in hardware.

Parameters:
WIDTH, 8, multiplier operand width; product width PW = 2*WIDTH.
CNT_W, 32, width of sample target and all sample counters.
ACC_W, 48, width of sum accumulators (sum_aed unsigned, sum_ed two's complement).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse: clear all results, latch num_samples, begin a run.
num_samples  in  CNT_W  sample target, sampled only on start.
in_valid  in  1  exact/apprx pair valid.
in_ready  out  1  monitor can accept a pair this cycle.
in_exact  in  PW  exact product (unsigned).
in_apprx  in  PW  approximate product (unsigned).
busy  out  1  state is RUN.
done  out  1  state is DONE; results final.
accepted  out  CNT_W  pairs accepted this run.
err_count  out  CNT_W  pairs with exact != apprx.
nz_count  out  CNT_W  pairs with exact != 0.
sum_aed  out  ACC_W  sum of |exact - apprx|.
sum_ed  out  ACC_W  signed sum of (exact - apprx).
max_aed  out  PW  largest |exact - apprx| seen.
max_exact  out  PW  exact value at the first occurrence of max_aed.
sat  out  1  sticky: some accumulator saturated this run.

Behaviour:
- Reset, asynchronous: state IDLE. All outputs 0, including in_ready, busy, done and sat. Pipeline valid bits cleared.
- FSM IDLE -> RUN on start. RUN -> DRAIN when accepted reaches target. DRAIN -> DONE when both pipeline stages are empty. DONE -> RUN on start.
- start in any state (including RUN/DRAIN): all counters, sums, max values and sat clear to 0 and the pipeline is flushed. num_samples is latched and the FSM enters RUN next cycle. If num_samples == 0, it goes to DONE next cycle instead, with all results 0.
- Handshake: in_ready = (state == RUN) && (accepted < target). A transfer occurs when in_valid && in_ready. accepted increments in the transfer cycle. in_ready deasserts combinationally once accepted == target. in_valid without in_ready is ignored; no buffering.
- Stage 1 (registered on transfer):
  - d = exact - apprx, computed at PW+1 bits signed.
  - a = |d|, PW bits.
  - ne = (d != 0).
  - nz = (exact != 0).
  - exact is carried forward.
- Stage 2 (registered): err_count += ne; nz_count += nz; sum_aed += a; sum_ed += sign-extended d.
- Peak tracking: max_aed and max_exact update only when a > max_aed (strictly greater), so ties keep the first occurrence.
- Latency: a pair accepted at edge t is reflected in all result outputs after edge t+2. done asserts no earlier than 2 cycles after the final transfer.
- Saturation:
  - sum_aed clamps at 2^ACC_W-1.
  - sum_ed clamps at +2^(ACC_W-1)-1 and -2^(ACC_W-1).
  - Counters cannot overflow because they are bounded by the target.
  - Any clamp sets sat, which holds until start or rst.
- Results hold stable in DONE until start or rst.
- Mid-run rst: immediate return to reset values; any partially accepted run is discarded.

Test Plan:
- WIDTH=8; start with num_samples=3; pairs (exact,apprx) = (100,96), (50,50), (0,4) -> done after final transfer +2 cycles; accepted=3, err_count=2, nz_count=2, sum_aed=8, sum_ed=0, max_aed=4, max_exact=100 (tie with 4 keeps first), sat=0.
- start with num_samples=0 -> done=1 one cycle later, all results 0, in_ready never asserts.
- num_samples=2, in_valid held high for 5 cycles -> exactly 2 transfers, in_ready low from the cycle after the 2nd transfer, accepted=2.
- ACC_W=18 override, WIDTH=8, 8 pairs (65025,0) -> sum_aed clamps at 262143, sat=1; restart with start -> sat=0, sum_aed=0.
- Assert start mid-run after 5 of 10 pairs, then 4 pairs of (10,7) with num_samples=4 -> accepted=4, sum_aed=12, sum_ed=12, max_aed=3, max_exact=10; no contribution from the earlier 5.
- Pulse rst asynchronously between clock edges during DRAIN -> all outputs 0 immediately, state IDLE, and a subsequent start runs normally.
